// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order writeback FIFO in front of the 32x64 register file.
// Drains one request per cycle onto the registered regfile write port and
// silently drops writes to X31 (hardwired zero).
// Optional read bypass over pending writes: define REGFILE_WQ_BYPASS_EN.
module regfile_write_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4:0]                   in_reg,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         drain_en,
    output logic                         regWrite,
    output logic [4:0]                   writeRegister,
    output logic [WIDTH-1:0]             writeData,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
`ifdef REGFILE_WQ_BYPASS_EN
    ,
    input  logic [4:0]                   readRegister1,
    input  logic [4:0]                   readRegister2,
    output logic                         hit1,
    output logic                         hit2,
    output logic [WIDTH-1:0]             bypassData1,
    output logic [WIDTH-1:0]             bypassData2
`endif
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW       = $clog2(DEPTH + 1);
    localparam logic [4:0]  ZERO_REG = 5'd31;

    logic [4:0]       r_reg_q  [DEPTH];
    logic [WIDTH-1:0] r_data_q [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_wr;
    logic [4:0]       r_wreg;
    logic [WIDTH-1:0] r_wdata;

    logic w_empty;
    logic w_full;
    logic w_accept;
    logic w_push;
    logic w_pop;

    // Handshake and queue control; X31 requests complete the handshake but are never stored
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign in_ready = reset & ~w_full;
    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & (in_reg != ZERO_REG);
    assign w_pop    = drain_en & ~w_empty;

    assign count         = r_count;
    assign empty         = w_empty;
    assign full          = w_full;
    assign regWrite      = r_wr;
    assign writeRegister = r_wreg;
    assign writeData     = r_wdata;

    // Pointers and explicit occupancy count; reset discards all pending entries
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful inside the occupied window
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg_q[r_wptr]  <= in_reg;
            r_data_q[r_wptr] <= in_data;
        end
    end

    // Staged regfile write port; address/data hold between pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else begin
            r_wr <= w_pop;
            if (w_pop) begin
                r_wreg  <= r_reg_q[r_rptr];
                r_wdata <= r_data_q[r_rptr];
            end
        end
    end

`ifdef REGFILE_WQ_BYPASS_EN
    // Youngest-match search: staged write is oldest, then queue head through tail
    function automatic logic [WIDTH:0] f_lookup(input logic [4:0] addr);
        logic             hit;
        logic [WIDTH-1:0] data;
        logic [AW-1:0]    idx;
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        if (addr != ZERO_REG) begin
            if (r_wr && (r_wreg == addr)) begin
                hit  = 1'b1;
                data = r_wdata;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = r_rptr + AW'(i);
                if ((CW'(i) < r_count) && (r_reg_q[idx] == addr)) begin
                    hit  = 1'b1;
                    data = r_data_q[idx];
                end
            end
        end
        return {hit, data};
    endfunction

    // Combinational bypass lookup for both read ports
    always_comb begin
        {hit1, bypassData1} = f_lookup(readRegister1);
        {hit2, bypassData2} = f_lookup(readRegister2);
    end
`endif

endmodule
